// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//
// Parametrised register file for the custom processor with a per-register busy
// scoreboard. Two combinational read ports, one synchronous write-back port,
// and a reservation port used at issue to mark a destination as pending.
// R0 is hardwired to zero, is never busy and ignores writes/reservations.
//
// Parameters:
//   WIDTH  data width of each register (default 16)
//   NREGS  number of registers, power of two, >= 2 (default 4)
//   AW     derived address width, $clog2(NREGS); not overridable
//
// Ports:
//   clk          in   1        system clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   rs1_addr     in   AW       read port 1 address
//   rs2_addr     in   AW       read port 2 address
//   rs1_data     out  WIDTH    read port 1 data (combinational)
//   rs2_data     out  WIDTH    read port 2 data (combinational)
//   rs1_busy     out  1        rs1_addr has a pending write
//   rs2_busy     out  1        rs2_addr has a pending write
//   rsv_en       in   1        reserve destination at issue
//   rsv_rd       in   AW       destination to reserve
//   rsv_stall    out  1        reservation refused this cycle (WAW)
//   wb_en        in   1        write-back enable
//   wb_rd        in   AW       write-back destination
//   wb_data      in   WIDTH    write-back data
//   pending_cnt  out  AW+1     number of busy registers (registered)
//   wb_err       out  1        sticky: write-back to a non-busy register
//
// Configuration macro:
//   REGFILE_BYPASS_EN  when defined, a write-back in progress is forwarded to
//                      any read port addressing the same (non-zero) register
//                      in the same cycle, with busy shown as 0.
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_rd,
    output logic             rsv_stall,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic [AW:0]      pending_cnt,
    output logic             wb_err
);

    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             wb_err_q;
    logic             wb_err_d;

    logic             wb_take;
    logic             rsv_take;
    logic             wb_hit_busy;

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    always_comb begin
        wb_take     = wb_en && (wb_rd != '0);
        wb_hit_busy = wb_take && busy_q[wb_rd];
        // A busy destination may be re-reserved only if it is being retired
        // in the same cycle.
        rsv_stall   = rsv_en && (rsv_rd != '0) && busy_q[rsv_rd]
                      && !(wb_en && (wb_rd == rsv_rd));
        rsv_take    = rsv_en && (rsv_rd != '0) && !rsv_stall;
    end

    // -------------------------------------------------------------------------
    // Scoreboard next state
    // -------------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        // Clear first, then set, so a same-register reserve overrides the
        // write-back and the register stays busy.
        if (wb_take) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (rsv_take) begin
            busy_d[rsv_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        cnt_d = cnt_q;
        if (rsv_take && !wb_hit_busy) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (wb_hit_busy && !rsv_take) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        wb_err_d = wb_err_q | (wb_take && !busy_q[wb_rd]);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            cnt_q    <= '0;
            wb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            wb_err_q <= wb_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_take) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    always_comb begin
        rs1_data = regs_q[rs1_addr];
        rs2_data = regs_q[rs2_addr];
        rs1_busy = busy_q[rs1_addr];
        rs2_busy = busy_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        // wb_take already excludes R0, so R0 is never forwarded.
        if (wb_take && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
            rs1_busy = 1'b0;
        end
        if (wb_take && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
            rs2_busy = 1'b0;
        end
`endif
    end

    assign pending_cnt = cnt_q;
    assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
//
// Self-checking bench for reg_file_sb. A default (4x16) instance runs a table
// of stimulus/expected records through a scoreboard queue; an 8x32 instance
// runs hand-written sequences for full occupancy and mid-operation reset.
// Honours REGFILE_BYPASS_EN for the same-cycle forwarding expectations.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    // 4 x 16 instance
    logic [1:0]  a1, a2, rsv_rd, wb_rd;
    logic        rsv_en, wb_en;
    logic [15:0] wb_data, d1, d2;
    logic        b1, b2, stall, err;
    logic [2:0]  cnt;

    // 8 x 32 instance
    logic [2:0]  a1_8, a2_8, rsv_rd_8, wb_rd_8;
    logic        rsv_en_8, wb_en_8;
    logic [31:0] wb_data_8, d1_8, d2_8;
    logic        b1_8, b2_8, stall_8, err_8;
    logic [3:0]  cnt_8;

    int checks   = 0;
    int failures = 0;

    reg_file_sb dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(a1), .rs2_addr(a2),
        .rs1_data(d1), .rs2_data(d2),
        .rs1_busy(b1), .rs2_busy(b2),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd), .rsv_stall(stall),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .pending_cnt(cnt), .wb_err(err)
    );

    reg_file_sb #(.WIDTH(32), .NREGS(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(a1_8), .rs2_addr(a2_8),
        .rs1_data(d1_8), .rs2_data(d2_8),
        .rs1_busy(b1_8), .rs2_busy(b2_8),
        .rsv_en(rsv_en_8), .rsv_rd(rsv_rd_8), .rsv_stall(stall_8),
        .wb_en(wb_en_8), .wb_rd(wb_rd_8), .wb_data(wb_data_8),
        .pending_cnt(cnt_8), .wb_err(err_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  a1, a2;
        logic        rsv_en;
        logic [1:0]  rsv_rd;
        logic        wb_en;
        logic [1:0]  wb_rd;
        logic [15:0] wb_data;
        logic [15:0] e_d1;
        logic        e_b1;
        logic [15:0] e_d2;
        logic        e_b2;
        logic        e_stall;
        logic [2:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(
        input logic [1:0] va1, input logic [1:0] va2,
        input logic vre, input logic [1:0] vrr,
        input logic vwe, input logic [1:0] vwr, input logic [15:0] vwd,
        input logic [15:0] ed1, input logic eb1,
        input logic [15:0] ed2, input logic eb2,
        input logic est, input logic [2:0] ec, input logic ee);
        vec_t v;
        v.a1 = va1; v.a2 = va2; v.rsv_en = vre; v.rsv_rd = vrr;
        v.wb_en = vwe; v.wb_rd = vwr; v.wb_data = vwd;
        v.e_d1 = ed1; v.e_b1 = eb1; v.e_d2 = ed2; v.e_b2 = eb2;
        v.e_stall = est; v.e_cnt = ec; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        vec_t e;

        rst_n = 1'b0;
        a1 = '0; a2 = '0; rsv_en = 0; rsv_rd = '0; wb_en = 0; wb_rd = '0; wb_data = '0;
        a1_8 = '0; a2_8 = '0; rsv_en_8 = 0; rsv_rd_8 = '0; wb_en_8 = 0; wb_rd_8 = '0; wb_data_8 = '0;

        //        a1 a2 re rr we wr wdata     | d1 b1 d2 b2 st cnt err
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(2, 3, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 1, 2, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 1, 2, 16'h1234, BYP ? 16'h1234 : 16'h0000, !BYP, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 0, 16'h0000, 16'h1234, 0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(3, 0, 1, 3, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(3, 0, 1, 3, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 1, 1, 0));
        vecs.push_back(mk(3, 2, 1, 3, 1, 3, 16'hAAAA, BYP ? 16'hAAAA : 16'h0000, !BYP, 16'h1234, 0, 0, 1, 0));
        vecs.push_back(mk(3, 2, 0, 0, 0, 0, 16'h0000, 16'hAAAA, 1, 16'h1234, 0, 0, 1, 0));
        vecs.push_back(mk(3, 0, 0, 0, 1, 3, 16'h5555, BYP ? 16'h5555 : 16'hAAAA, !BYP, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3, 1, 0, 1, 0, 16'hFFFF, 16'h0000, 0, 16'h5555, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 16'h0005, 16'h0000, 0, BYP ? 16'h0005 : 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0005, 0, 16'h0000, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 16'hBEEF, BYP ? 16'hBEEF : 16'h0005, 0, 16'h0000, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'hBEEF, 0, 16'h0000, 0, 0, 0, 1));
        vecs.push_back(mk(1, 2, 1, 1, 1, 2, 16'h0077, 16'hBEEF, 0, BYP ? 16'h0077 : 16'h1234, 0, 0, 0, 1));
        vecs.push_back(mk(1, 2, 1, 2, 1, 1, 16'h0099, BYP ? 16'h0099 : 16'hBEEF, !BYP, 16'h0077, 0, 0, 1, 1));
        vecs.push_back(mk(1, 2, 0, 0, 0, 0, 16'h0000, 16'h0099, 0, 16'h0077, 1, 0, 1, 1));
        vecs.push_back(mk(2, 0, 1, 2, 0, 0, 16'h0000, 16'h0077, 1, 16'h0000, 0, 1, 1, 1));
        vecs.push_back(mk(3, 2, 1, 3, 1, 2, 16'h0001, 16'h5555, 0, BYP ? 16'h0001 : 16'h0077, !BYP, 0, 1, 1));
        vecs.push_back(mk(3, 2, 0, 0, 0, 0, 16'h0000, 16'h5555, 1, 16'h0001, 0, 0, 1, 1));

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state of both instances
        @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            a1 = 2'(a); a2 = 2'(3 - a);
            #1;
            check($sformatf("rst.rs1_data[%0d]", a), 32'(d1), 32'h0);
            check($sformatf("rst.rs1_busy[%0d]", a), 32'(b1), 32'h0);
            check($sformatf("rst.rs2_data[%0d]", 3 - a), 32'(d2), 32'h0);
        end
        check("rst.pending_cnt", 32'(cnt), 32'h0);
        check("rst.wb_err", 32'(err), 32'h0);
        check("rst8.pending_cnt", 32'(cnt_8), 32'h0);
        check("rst8.wb_err", 32'(err_8), 32'h0);

        // Table-driven vectors through the scoreboard
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            a1 = vecs[i].a1; a2 = vecs[i].a2;
            rsv_en = vecs[i].rsv_en; rsv_rd = vecs[i].rsv_rd;
            wb_en = vecs[i].wb_en; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_data;
            sb.push_back(vecs[i]);
            #2;
            e = sb.pop_front();
            check($sformatf("v%0d.rs1_data", i), 32'(d1), 32'(e.e_d1));
            check($sformatf("v%0d.rs1_busy", i), 32'(b1), 32'(e.e_b1));
            check($sformatf("v%0d.rs2_data", i), 32'(d2), 32'(e.e_d2));
            check($sformatf("v%0d.rs2_busy", i), 32'(b2), 32'(e.e_b2));
            check($sformatf("v%0d.rsv_stall", i), 32'(stall), 32'(e.e_stall));
            check($sformatf("v%0d.pending_cnt", i), 32'(cnt), 32'(e.e_cnt));
            check($sformatf("v%0d.wb_err", i), 32'(err), 32'(e.e_err));
        end
        @(negedge clk);
        rsv_en = 0; wb_en = 0;

        // 8 x 32: write-back to a non-busy register, then fill the scoreboard
        a1_8 = 3'd5; a2_8 = 3'd6;
        wb_en_8 = 1; wb_rd_8 = 3'd5; wb_data_8 = 32'hDEADBEEF;
        @(negedge clk);
        wb_en_8 = 0;
        #1;
        check("s8.r5_data", d1_8, 32'hDEADBEEF);
        check("s8.wb_err", 32'(err_8), 32'h1);
        for (int r = 1; r < 8; r++) begin
            @(negedge clk);
            rsv_en_8 = 1; rsv_rd_8 = 3'(r);
            #1;
            check($sformatf("s8.stall_r%0d", r), 32'(stall_8), 32'h0);
            check($sformatf("s8.cnt_before_r%0d", r), 32'(cnt_8), 32'(r - 1));
        end
        @(negedge clk);
        rsv_rd_8 = 3'd4;
        #1;
        check("s8.pending_full", 32'(cnt_8), 32'd7);
        check("s8.r5_busy", 32'(b1_8), 32'h1);
        check("s8.restall_r4", 32'(stall_8), 32'h1);
        @(negedge clk);
        rsv_en_8 = 0;
        #1;
        check("s8.pending_after_stall", 32'(cnt_8), 32'd7);

        // Asynchronous reset mid-sequence with a write-back held active
        @(negedge clk);
        wb_en_8 = 1; wb_rd_8 = 3'd6; wb_data_8 = 32'h12345678;
        #1;
        rst_n = 1'b0;
        #1;
        check("s8.async_cnt", 32'(cnt_8), 32'h0);
        check("s8.async_r5_data", d1_8, 32'h0);
        check("s8.async_r5_busy", 32'(b1_8), 32'h0);
        check("s8.async_r6_busy", 32'(b2_8), 32'h0);
        check("s8.async_wb_err", 32'(err_8), 32'h0);
        check("s4.async_cnt", 32'(cnt), 32'h0);
        @(posedge clk);
        #1;
        check("s8.no_wb_in_reset", d2_8, 32'h0);
        @(negedge clk);
        wb_en_8 = 0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("s8.post_rst_r6", d2_8, 32'h0);
        check("s8.post_rst_cnt", 32'(cnt_8), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 4x16 custom-processor register file.
- Configurable width and register count; two combinational read ports and one synchronous write-back port.
- Adds a per-register busy scoreboard: reserve at issue, clear at write-back, with hazard/stall outputs.
- Sits between decode/issue and the ALU write-back path of the custom processor.

Parameters:
- WIDTH, 16, data width of each register.
- NREGS, 4, number of architectural registers (power of two, >= 2).
- AW, $clog2(NREGS), derived localparam; address width. Not overridable.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  WIDTH  read port 1 data (combinational).
- rs2_data  out  WIDTH  read port 2 data (combinational).
- rs1_busy  out  1  rs1_addr has a pending write (RAW hazard).
- rs2_busy  out  1  rs2_addr has a pending write (RAW hazard).
- rsv_en  in  1  reserve destination at issue.
- rsv_rd  in  AW  destination register to reserve.
- rsv_stall  out  1  reservation refused this cycle (WAW hazard).
- wb_en  in  1  write-back enable.
- wb_rd  in  AW  write-back destination.
- wb_data  in  WIDTH  write-back data.
- pending_cnt  out  AW+1  number of busy registers.
- wb_err  out  1  sticky: write-back hit a non-busy register.

Behaviour:
- Reset (rst_n low, async):
  - All registers = 0.
  - All busy bits = 0, pending_cnt = 0, wb_err = 0.
  - Reset mid-operation discards all reservations immediately; no write-back is taken while rst_n is low.
- R0 is hardwired:
  - Always reads 0 and is never busy.
  - Writes and reservations to address 0 are ignored.
  - rsv_stall is never asserted for rsv_rd = 0.
- Reads:
  - rsX_data = reg[rsX_addr], combinational.
  - rsX_busy = busy[rsX_addr], combinational.
- Write-back (rising edge):
  - If wb_en and wb_rd != 0: reg[wb_rd] <= wb_data and busy[wb_rd] <= 0.
  - If busy[wb_rd] was 0 at that edge, the data is still written and wb_err <= 1.
  - wb_err stays set until reset.
- Reservation:
  - rsv_stall = rsv_en & (rsv_rd != 0) & busy[rsv_rd] & ~(wb_en & wb_rd == rsv_rd). Combinational.
  - If rsv_en, rsv_rd != 0 and not rsv_stall: busy[rsv_rd] <= 1 at the edge.
- Simultaneous reserve and write-back, same register:
  - Write-back data is stored.
  - The new reservation wins; busy stays 1.
  - Not counted as a stall.
- Simultaneous reserve and write-back, different registers: both take effect.
- pending_cnt:
  - Registered.
  - Updated each edge to +1 (reserve only), -1 (write-back of a busy register only), or unchanged (both, or neither).
  - Equals the popcount of busy at all times after the edge.
  - Maximum value NREGS-1; no wrap.
- Latency:
  - Write-back is visible on the read ports the cycle after the edge (unless bypass is enabled, see below).
  - A reservation is visible on rsX_busy the cycle after the edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When wb_en and wb_rd == rsX_addr != 0, rsX_data = wb_data and rsX_busy = 0 in the same cycle.
  - This is a write-through forward.
- Undefined:
  - Read ports show the stored value and the current busy bit.
  - The new value and busy = 0 appear one cycle after the write-back edge.

Test Plan:
- Reset, then read all addresses -> all rsX_data = 0, busy = 0, pending_cnt = 0, wb_err = 0.
- Reserve r2, then next cycle wb r2 = 0x1234 -> rs1_busy = 1 for one cycle, then r2 reads 0x1234, busy = 0, pending_cnt 1 -> 0.
- Reserve r3, then reserve r3 again -> second cycle rsv_stall = 1, pending_cnt stays 1; wb r3 with rsv r3 in the same cycle -> no stall, busy = 1, data stored.
- wb r0 = 0xFFFF, rsv r0 -> r0 reads 0, never busy, no stall; wb r1 = 0x5 while r1 is not busy -> r1 = 0x5, wb_err = 1 and remains set.
- With REGFILE_BYPASS_EN defined: rs1_addr = 1, wb r1 = 0xBEEF -> rs1_data = 0xBEEF and rs1_busy = 0 in the same cycle. Undefined: old value shown, 0xBEEF on the next cycle.
- NREGS = 8, WIDTH = 32: reserve r1..r7 -> pending_cnt = 7. Assert rst_n low mid-sequence -> immediate clear to 0, no further writes.
